// File: rtl/shift_operand_gen.sv
// Operand-2 producer for the barrel shifter: decodes an ARMv7 data-processing
// instruction, fetches Rm/Rs through one read port, and holds operands under valid/ready.
module shift_operand_gen #(
    parameter logic [31:0] PC_OFFSET_IMM = 32'd8,
    parameter logic [31:0] PC_OFFSET_REG = 32'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Flush,
    input  logic        Inst_Valid,
    output logic        Inst_Ready,
    input  logic [32:1] Inst,
    input  logic [32:1] Inst_Pc,
    output logic        Rd_En,
    output logic [4:1]  Rd_Addr,
    input  logic [32:1] Rd_Data,
    output logic        Op_Valid,
    input  logic        Op_Ready,
    output logic [32:1] Shift_Data,
    output logic [8:1]  Shift_Num,
    output logic [3:1]  SHIFT_OP
);

    typedef enum logic [1:0] {IDLE, READ_RM, READ_RS, OUT} state_t;

    state_t      state, state_nxt;
    logic [12:1] inst_q, inst_nxt;
    logic [32:1] pc_q, pc_nxt;

    logic        rd_en_nxt;
    logic [4:1]  rd_addr_nxt;
    logic        op_valid_nxt;
    logic [32:1] shift_data_nxt;
    logic [8:1]  shift_num_nxt;
    logic [3:1]  shift_op_nxt;

    // r15 reads return the pipeline-visible PC; R selects the register-shift offset.
    logic [32:1] rm_pc;
    logic [8:1]  rs_pc_low;
    logic        rm_is_pc;
    logic        rs_is_pc;

    assign rm_pc     = pc_q + (inst_q[5] ? PC_OFFSET_REG : PC_OFFSET_IMM);
    assign rs_pc_low = pc_q[8:1] + PC_OFFSET_REG[7:0];
    assign rm_is_pc  = (inst_q[4:1] == 4'hF);
    assign rs_is_pc  = (inst_q[12:9] == 4'hF);

    assign Inst_Ready = (state == IDLE);

    // Only the operand-2 field and the I bit of the instruction matter here.
    logic unused_inst_bits;
    assign unused_inst_bits = &{1'b0, Inst[32:27], Inst[25:13]};

    // NOTE: every next-value signal takes a default before the case statement,
    // so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        inst_nxt       = inst_q;
        pc_nxt         = pc_q;
        rd_en_nxt      = Rd_En;
        rd_addr_nxt    = Rd_Addr;
        op_valid_nxt   = Op_Valid;
        shift_data_nxt = Shift_Data;
        shift_num_nxt  = Shift_Num;
        shift_op_nxt   = SHIFT_OP;

        case (state)
            IDLE: begin
                if (Inst_Valid) begin
                    inst_nxt = Inst[12:1];
                    pc_nxt   = Inst_Pc;
                    if (Inst[26]) begin
                        // Rotated immediate goes out as register-form ROR so rot=0 passes C through.
                        shift_data_nxt = {24'b0, Inst[8:1]};
                        shift_num_nxt  = {3'b0, Inst[12:9], 1'b0};
                        shift_op_nxt   = 3'b111;
                        op_valid_nxt   = 1'b1;
                        state_nxt      = OUT;
                    end else begin
                        if (Inst[4:1] != 4'hF) begin
                            rd_en_nxt   = 1'b1;
                            rd_addr_nxt = Inst[4:1];
                        end
                        state_nxt = READ_RM;
                    end
                end
            end
            READ_RM: begin
                shift_data_nxt = rm_is_pc ? rm_pc : Rd_Data;
                if (inst_q[5]) begin
                    rd_en_nxt = !rs_is_pc;
                    if (!rs_is_pc) begin
                        rd_addr_nxt = inst_q[12:9];
                    end
                    state_nxt = READ_RS;
                end else begin
                    rd_en_nxt     = 1'b0;
                    shift_num_nxt = {3'b0, inst_q[12:8]};
                    shift_op_nxt  = {inst_q[7:6], 1'b0};
                    op_valid_nxt  = 1'b1;
                    state_nxt     = OUT;
                end
            end
            READ_RS: begin
                rd_en_nxt     = 1'b0;
                shift_num_nxt = rs_is_pc ? rs_pc_low : Rd_Data[8:1];
                shift_op_nxt  = {inst_q[7:6], 1'b1};
                op_valid_nxt  = 1'b1;
                state_nxt     = OUT;
            end
            OUT: begin
                if (Op_Ready) begin
                    op_valid_nxt = 1'b0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (Flush) begin
            state_nxt      = IDLE;
            rd_en_nxt      = 1'b0;
            rd_addr_nxt    = 4'h0;
            op_valid_nxt   = 1'b0;
            shift_data_nxt = 32'h0;
            shift_num_nxt  = 8'h0;
            shift_op_nxt   = 3'b000;
        end
    end

    // NOTE: all state, including the latched instruction, is cleared by reset
    // and updated with non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            inst_q     <= '0;
            pc_q       <= '0;
            Rd_En      <= 1'b0;
            Rd_Addr    <= '0;
            Op_Valid   <= 1'b0;
            Shift_Data <= '0;
            Shift_Num  <= '0;
            SHIFT_OP   <= '0;
        end else begin
            state      <= state_nxt;
            inst_q     <= inst_nxt;
            pc_q       <= pc_nxt;
            Rd_En      <= rd_en_nxt;
            Rd_Addr    <= rd_addr_nxt;
            Op_Valid   <= op_valid_nxt;
            Shift_Data <= shift_data_nxt;
            Shift_Num  <= shift_num_nxt;
            SHIFT_OP   <= shift_op_nxt;
        end
    end

endmodule

// File: tb/tb_shift_operand_gen.sv
// Directed bench for shift_operand_gen with a small combinational register-file model.
module tb_shift_operand_gen;

    logic        clk;
    logic        rst;
    logic        Flush;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [32:1] Inst;
    logic [32:1] Inst_Pc;
    logic        Rd_En;
    logic [4:1]  Rd_Addr;
    logic [32:1] Rd_Data;
    logic        Op_Valid;
    logic        Op_Ready;
    logic [32:1] Shift_Data;
    logic [8:1]  Shift_Num;
    logic [3:1]  SHIFT_OP;

    logic [31:0] rf [16];
    int n_checks = 0;
    int n_fail   = 0;

    shift_operand_gen dut (
        .clk        (clk),
        .rst        (rst),
        .Flush      (Flush),
        .Inst_Valid (Inst_Valid),
        .Inst_Ready (Inst_Ready),
        .Inst       (Inst),
        .Inst_Pc    (Inst_Pc),
        .Rd_En      (Rd_En),
        .Rd_Addr    (Rd_Addr),
        .Rd_Data    (Rd_Data),
        .Op_Valid   (Op_Valid),
        .Op_Ready   (Op_Ready),
        .Shift_Data (Shift_Data),
        .Shift_Num  (Shift_Num),
        .SHIFT_OP   (SHIFT_OP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb Rd_Data = rf[Rd_Addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] i, input logic [31:0] pc);
        check("inst_ready_before_accept", Inst_Ready, 1);
        Inst_Valid = 1'b1;
        Inst       = i;
        Inst_Pc    = pc;
        tick();
        Inst_Valid = 1'b0;
    endtask

    task automatic expect_ops(input string tag, input logic [31:0] d, input logic [31:0] n,
                              input logic [31:0] op);
        check({tag, "_valid"}, Op_Valid, 1);
        check({tag, "_data"}, Shift_Data, d);
        check({tag, "_num"}, Shift_Num, n);
        check({tag, "_op"}, SHIFT_OP, op);
        check({tag, "_inst_ready"}, Inst_Ready, 0);
    endtask

    task automatic handshake(input string tag);
        Op_Ready = 1'b1;
        tick();
        Op_Ready = 1'b0;
        check({tag, "_valid_drop"}, Op_Valid, 0);
        check({tag, "_back_idle"}, Inst_Ready, 1);
    endtask

    initial begin
        for (int r = 0; r < 16; r++) rf[r] = 32'hA5A5_0000 + r;
        rf[2] = 32'h1234_5678;
        rf[3] = 32'h0000_0121;
        rst = 1'b1; Flush = 1'b0; Inst_Valid = 1'b0; Op_Ready = 1'b0;
        Inst = '0; Inst_Pc = '0;
        #2;
        check("rst_op_valid", Op_Valid, 0);
        check("rst_rd_en", Rd_En, 0);
        check("rst_shift_data", Shift_Data, 0);
        check("rst_shift_num", Shift_Num, 0);
        check("rst_shift_op", SHIFT_OP, 0);
        check("rst_inst_ready", Inst_Ready, 1);
        tick();
        rst = 1'b0;
        tick();

        // Rotated immediate: 0xFF ror 8, one cycle to valid, no register read.
        accept(32'hE3A014FF, 32'h0000_0100);
        check("imm_rd_en", Rd_En, 0);
        expect_ops("imm", 32'h0000_00FF, 8, 3'b111);
        handshake("imm");

        // Register shifted by immediate: r2 LSL #3, two cycles.
        accept(32'hE0810182, 32'h0000_0200);
        check("lsl_rd_en", Rd_En, 1);
        check("lsl_rd_addr", Rd_Addr, 2);
        check("lsl_not_yet", Op_Valid, 0);
        tick();
        check("lsl_rd_en_off", Rd_En, 0);
        expect_ops("lsl", 32'h1234_5678, 3, 3'b000);
        handshake("lsl");

        // Register shifted by register: r2 ASR r3, three cycles, then 5-cycle stall.
        rf[2] = 32'h8000_0000;
        accept(32'hE0810352, 32'h0000_0300);
        check("asr_rm_en", Rd_En, 1);
        check("asr_rm_addr", Rd_Addr, 2);
        check("asr_not_yet1", Op_Valid, 0);
        tick();
        check("asr_rs_en", Rd_En, 1);
        check("asr_rs_addr", Rd_Addr, 3);
        check("asr_not_yet2", Op_Valid, 0);
        tick();
        expect_ops("asr", 32'h8000_0000, 8'h21, 3'b101);
        for (int c = 0; c < 5; c++) begin
            tick();
            expect_ops("asr_stall", 32'h8000_0000, 8'h21, 3'b101);
        end
        handshake("asr");

        // Rm = r15, immediate shift: PC + 8.
        accept(32'hE081000F, 32'h0000_1000);
        check("pc_imm_rd_en", Rd_En, 0);
        tick();
        check("pc_imm_rd_en2", Rd_En, 0);
        expect_ops("pc_imm", 32'h0000_1008, 0, 3'b000);
        handshake("pc_imm");

        // Rm = r15, register shift: PC + 12; Rd_Addr holds until Rs read.
        accept(32'hE081031F, 32'h0000_1000);
        check("pc_reg_rd_en", Rd_En, 0);
        check("pc_reg_addr_hold", Rd_Addr, 3);
        tick();
        check("pc_reg_rs_en", Rd_En, 1);
        check("pc_reg_rs_addr", Rd_Addr, 3);
        tick();
        expect_ops("pc_reg", 32'h0000_100C, 8'h21, 3'b001);
        handshake("pc_reg");

        // PC offset wraps at 32 bits.
        accept(32'hE081000F, 32'hFFFF_FFFC);
        tick();
        expect_ops("pc_wrap", 32'h0000_0004, 0, 3'b000);
        handshake("pc_wrap");

        // Rs = r15: amount is low byte of PC + 12.
        rf[2] = 32'hCAFE_F00D;
        accept(32'hE0810F12, 32'h0000_1000);
        check("rs_pc_rm_en", Rd_En, 1);
        tick();
        check("rs_pc_rs_en", Rd_En, 0);
        tick();
        expect_ops("rs_pc", 32'hCAFE_F00D, 8'h0C, 3'b001);
        handshake("rs_pc");

        // Flush while in READ_RS drops the op and clears outputs.
        accept(32'hE0810352, 32'h0000_0400);
        tick();
        check("flush_in_rs", Rd_Addr, 3);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        check("flush_op_valid", Op_Valid, 0);
        check("flush_rd_en", Rd_En, 0);
        check("flush_rd_addr", Rd_Addr, 0);
        check("flush_data", Shift_Data, 0);
        check("flush_num", Shift_Num, 0);
        check("flush_op", SHIFT_OP, 0);
        check("flush_idle", Inst_Ready, 1);
        tick();
        check("flush_no_valid", Op_Valid, 0);

        // Flush beats an accept in the same cycle.
        Flush = 1'b1; Inst_Valid = 1'b1; Inst = 32'hE3A014FF;
        tick();
        Flush = 1'b0; Inst_Valid = 1'b0;
        check("flush_vs_accept_idle", Inst_Ready, 1);
        tick();
        check("flush_vs_accept_valid", Op_Valid, 0);
        check("flush_vs_accept_data", Shift_Data, 0);

        // Give outputs nonzero values, then reset asynchronously in READ_RM.
        accept(32'hE3A014FF, 32'h0);
        expect_ops("pre_rst", 32'h0000_00FF, 8, 3'b111);
        handshake("pre_rst");
        accept(32'hE0810182, 32'h0000_0500);
        check("rst_mid_rm_en", Rd_En, 1);
        #3;
        rst = 1'b1;
        #1;
        check("arst_rd_en", Rd_En, 0);
        check("arst_rd_addr", Rd_Addr, 0);
        check("arst_op_valid", Op_Valid, 0);
        check("arst_data", Shift_Data, 0);
        check("arst_num", Shift_Num, 0);
        check("arst_op", SHIFT_OP, 0);
        check("arst_idle", Inst_Ready, 1);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_no_valid", Op_Valid, 0);

        // Recovery after reset.
        rf[2] = 32'h1234_5678;
        accept(32'hE0810182, 32'h0);
        tick();
        expect_ops("recover", 32'h1234_5678, 3, 3'b000);
        handshake("recover");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
